// File: rtl/tmr_vote_if.sv
// Handshake and data bundle between the redundant producers, the voter and its consumer.
interface tmr_vote_if #(
   parameter int WIDTH = 8
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] ch_a;
   logic [WIDTH-1:0] ch_b;
   logic [WIDTH-1:0] ch_c;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] out_data;
   logic             out_corrected;
   logic             out_err;

   modport master (
      output in_valid, ch_a, ch_b, ch_c, out_ready,
      input  in_ready, out_valid, out_data, out_corrected, out_err
   );

   modport slave (
      input  in_valid, ch_a, ch_b, ch_c, out_ready,
      output in_ready, out_valid, out_data, out_corrected, out_err
   );
endinterface

// File: rtl/tmr_vote_ctrl.sv
// Triple-redundant voter with per-channel fault tracking, degrading from 3-way vote
// to 2-way compare to single-channel pass-through. One registered word per handshake.
module tmr_vote_ctrl #(
   parameter int WIDTH        = 8,
   parameter int FAULT_THRESH = 4
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       clear_faults,
   tmr_vote_if.slave  bus,
   output logic [2:0] fault_mask,
   output logic [1:0] state
);
   localparam int            CW     = $clog2(FAULT_THRESH + 1);
   localparam logic [CW-1:0] THRESH = CW'(FAULT_THRESH);

   typedef enum logic [1:0] {
      HEALTHY  = 2'b00,
      DEGRADED = 2'b01,
      FAILED   = 2'b10
   } mode_e;

   mode_e            mode_q, mode_d;
   logic [2:0]       mask_q, mask_d;
   logic [CW-1:0]    cnt_q [3];
   logic [CW-1:0]    cnt_d [3];
   logic [CW-1:0]    pair_q, pair_d;

   logic [WIDTH-1:0] a, b, c, voted, p, q, single, res_data;
   logic [2:0]       mism, hit, q_bit;
   logic             res_corr, res_err, accept;

   logic             out_valid_q, out_corr_q, out_err_q;
   logic [WIDTH-1:0] out_data_q;

   function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
      return (v == THRESH) ? v : v + CW'(1);
   endfunction

   assign a     = bus.ch_a;
   assign b     = bus.ch_b;
   assign c     = bus.ch_c;
   assign voted = (a & b) | (b & c) | (a & c);
   assign mism  = {c != voted, b != voted, a != voted};

   assign bus.in_ready = !out_valid_q | bus.out_ready;
   assign accept       = bus.in_valid & bus.in_ready;

   // Surviving pair in DEGRADED (P is the lower index) and the survivor in FAILED.
   always_comb begin
      p     = a;
      q     = b;
      q_bit = 3'b010;
      case (mask_q)
         3'b001:  begin p = b; q = c; q_bit = 3'b100; end
         3'b010:  begin p = a; q = c; q_bit = 3'b100; end
         default: ;
      endcase
      if (!mask_q[0])      single = a;
      else if (!mask_q[1]) single = b;
      else if (!mask_q[2]) single = c;
      else                 single = a;
   end

   always_comb begin
      // NOTE: every signal gets a default first so no latch is inferred.
      mode_d   = mode_q;
      mask_d   = mask_q;
      pair_d   = pair_q;
      hit      = '0;
      res_data = voted;
      res_corr = 1'b0;
      res_err  = 1'b0;
      for (int i = 0; i < 3; i++) cnt_d[i] = cnt_q[i];

      case (mode_q)
         HEALTHY: begin
            res_corr = |mism;
            if (accept) begin
               for (int i = 0; i < 3; i++) begin
                  cnt_d[i] = mism[i] ? sat_inc(cnt_q[i]) : '0;
                  hit[i]   = (cnt_d[i] == THRESH);
               end
               mask_d = mask_q | hit;
               if ($countones(hit) >= 2) mode_d = FAILED;
               else if (hit != 3'b000)   mode_d = DEGRADED;
            end
         end
         DEGRADED: begin
            res_data = p;
            res_err  = (p != q);
            if (accept) begin
               pair_d = res_err ? sat_inc(pair_q) : '0;
               if (pair_d == THRESH) begin
                  mode_d = FAILED;
                  mask_d = mask_q | q_bit;
               end
            end
         end
         default: begin
            res_data = single;
            res_err  = 1'b1;
         end
      endcase

      // Clearing overrides tracking, but the word accepted now keeps the old mode's result.
      if (clear_faults) begin
         mode_d = HEALTHY;
         mask_d = '0;
         pair_d = '0;
         for (int i = 0; i < 3; i++) cnt_d[i] = '0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mode_q <= HEALTHY;
         mask_q <= '0;
         pair_q <= '0;
         for (int i = 0; i < 3; i++) cnt_q[i] <= '0;
      end else begin
         // NOTE: non-blocking so every register samples pre-edge values together.
         mode_q <= mode_d;
         mask_q <= mask_d;
         pair_q <= pair_d;
         for (int i = 0; i < 3; i++) cnt_q[i] <= cnt_d[i];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_corr_q  <= 1'b0;
         out_err_q   <= 1'b0;
      end else if (accept) begin
         out_valid_q <= 1'b1;
         out_data_q  <= res_data;
         out_corr_q  <= res_corr;
         out_err_q   <= res_err;
      end else if (bus.out_ready) begin
         out_valid_q <= 1'b0;
      end
   end

   assign bus.out_valid     = out_valid_q;
   assign bus.out_data      = out_data_q;
   assign bus.out_corrected = out_corr_q;
   assign bus.out_err       = out_err_q;
   assign fault_mask        = mask_q;
   assign state             = mode_q;
endmodule

// File: tb/tb_tmr_vote_ctrl.sv
// Bench for tmr_vote_ctrl: vector table, directed degradation sequences and random
// traffic compared cycle by cycle against a behavioural model.
module tb_tmr_vote_ctrl;
   localparam int TH = 4;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       clear_faults;
   logic [2:0] fault_mask;
   logic [1:0] state;

   int n_checks = 0;
   int n_errors = 0;

   tmr_vote_if #(.WIDTH(8)) bus ();

   tmr_vote_ctrl #(.WIDTH(8), .FAULT_THRESH(TH)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .clear_faults (clear_faults),
      .bus          (bus),
      .fault_mask   (fault_mask),
      .state        (state)
   );

   always #5 clk = ~clk;

   // Behavioural model state
   logic       m_valid, m_corr, m_err;
   logic [7:0] m_data;
   logic [2:0] m_mask;
   logic [1:0] m_state;
   int         m_cnt [3];
   int         m_pair;

   typedef struct {
      logic [7:0] a, b, c;
      logic [7:0] exp_data;
      logic       exp_corr;
   } vec_t;
   vec_t vecs [7];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_valid = 0; m_corr = 0; m_err = 0; m_data = '0;
      m_mask = '0; m_state = 2'b00; m_pair = 0;
      for (int i = 0; i < 3; i++) m_cnt[i] = 0;
   endtask

   task automatic model_edge(input logic v, input logic [7:0] a, b, c,
                             input logic rdy, input logic clr);
      logic [7:0] ch [3];
      logic [7:0] vote, res;
      logic       corr, err;
      int         ups [$];
      int         hits;
      ch[0] = a; ch[1] = b; ch[2] = c;
      if (v && (!m_valid || rdy)) begin
         corr = 0; err = 0; res = '0;
         for (int i = 0; i < 3; i++) if (!m_mask[i]) ups.push_back(i);
         if (m_state == 2'b00) begin
            for (int k = 0; k < 8; k++)
               vote[k] = (int'(a[k]) + int'(b[k]) + int'(c[k])) >= 2;
            res = vote; hits = 0;
            for (int i = 0; i < 3; i++) begin
               if (ch[i] != vote) begin
                  corr = 1;
                  m_cnt[i] = (m_cnt[i] + 1 > TH) ? TH : m_cnt[i] + 1;
               end else m_cnt[i] = 0;
               if (m_cnt[i] == TH) begin hits++; m_mask[i] = 1'b1; end
            end
            if (hits >= 2) m_state = 2'b10;
            else if (hits == 1) m_state = 2'b01;
         end else if (m_state == 2'b01) begin
            res = ch[ups[0]];
            err = ch[ups[0]] != ch[ups[1]];
            m_pair = err ? ((m_pair + 1 > TH) ? TH : m_pair + 1) : 0;
            if (m_pair == TH) begin m_state = 2'b10; m_mask[ups[1]] = 1'b1; end
         end else begin
            res = (ups.size() > 0) ? ch[ups[0]] : ch[0];
            err = 1;
         end
         m_valid = 1; m_data = res; m_corr = corr; m_err = err;
      end else if (rdy) m_valid = 0;
      if (clr) begin
         m_mask = '0; m_state = 2'b00; m_pair = 0;
         for (int i = 0; i < 3; i++) m_cnt[i] = 0;
      end
   endtask

   task automatic check_outputs(input string tag);
      check({tag, "_out_valid"}, bus.out_valid, m_valid);
      check({tag, "_out_data"},  bus.out_data, m_data);
      check({tag, "_corrected"}, bus.out_corrected, m_corr);
      check({tag, "_out_err"},   bus.out_err, m_err);
      check({tag, "_mask"},      fault_mask, m_mask);
      check({tag, "_state"},     state, m_state);
   endtask

   task automatic cycle(input logic v, input logic [7:0] a, b, c,
                        input logic rdy, input logic clr, input string tag);
      bus.in_valid = v; bus.ch_a = a; bus.ch_b = b; bus.ch_c = c;
      bus.out_ready = rdy; clear_faults = clr;
      #1;
      check({tag, "_in_ready"}, bus.in_ready, !m_valid || rdy);
      @(posedge clk);
      model_edge(v, a, b, c, rdy, clr);
      #1;
      check_outputs(tag);
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0] base, va, vb, vc;
      vecs[0] = '{8'h5A, 8'h5A, 8'h5A, 8'h5A, 1'b0};
      vecs[1] = '{8'hFF, 8'h0F, 8'h3C, 8'h3F, 1'b1};
      vecs[2] = '{8'h00, 8'hFF, 8'h00, 8'h00, 1'b1};
      vecs[3] = '{8'hAA, 8'h55, 8'hFF, 8'hFF, 1'b1};
      vecs[4] = '{8'h12, 8'h12, 8'h34, 8'h12, 1'b1};
      vecs[5] = '{8'hF0, 8'h0F, 8'h00, 8'h00, 1'b1};
      vecs[6] = '{8'h81, 8'h81, 8'h81, 8'h81, 1'b0};

      rst_n = 1'b0; clear_faults = 0;
      bus.in_valid = 0; bus.out_ready = 0;
      bus.ch_a = '0; bus.ch_b = '0; bus.ch_c = '0;
      model_reset();
      repeat (2) @(posedge clk);
      @(negedge clk) rst_n = 1'b1;
      check_outputs("reset");

      // Vote table; clear_faults each word keeps counters from accumulating.
      for (int i = 0; i < 7; i++) begin
         cycle(1, vecs[i].a, vecs[i].b, vecs[i].c, 1, 1, "vec");
         check("vec_table_data", bus.out_data, vecs[i].exp_data);
         check("vec_table_corr", bus.out_corrected, vecs[i].exp_corr);
      end

      // Clean words, one-cycle latency
      for (int i = 0; i < 3; i++) begin
         cycle(1, 8'h5A, 8'h5A, 8'h5A, 1, 0, "t1");
         check("t1_data", bus.out_data, 8'h5A);
         check("t1_valid", bus.out_valid, 1);
      end

      // Three-way disagreement trips all counters together
      for (int i = 0; i < 4; i++) cycle(1, 8'hFF, 8'h0F, 8'h3C, 1, 0, "t2");
      check("t2_failed_state", state, 2'b10);
      check("t2_failed_mask", fault_mask, 3'b111);
      cycle(0, 0, 0, 0, 1, 1, "t2_clr");
      check("t2_cleared_state", state, 2'b00);

      // Good word breaks the run; then four consecutive bad words retire C
      for (int i = 0; i < 3; i++) cycle(1, 8'h3C, 8'h3C, 8'hC3, 1, 0, "t3a");
      cycle(1, 8'h3C, 8'h3C, 8'h3C, 1, 0, "t3g");
      for (int i = 0; i < 3; i++) cycle(1, 8'h3C, 8'h3C, 8'hC3, 1, 0, "t3b");
      check("t3_still_healthy", state, 2'b00);
      cycle(1, 8'h3C, 8'h3C, 8'hC3, 1, 0, "t3c");
      check("t3_degraded_state", state, 2'b01);
      check("t3_degraded_mask", fault_mask, 3'b100);

      // Pair disagreement in DEGRADED drives FAILED
      cycle(1, 8'h11, 8'h22, 8'h00, 1, 0, "t4");
      check("t4_data_p", bus.out_data, 8'h11);
      check("t4_err", bus.out_err, 1);
      for (int i = 0; i < 3; i++) cycle(1, 8'h11, 8'h22, 8'h00, 1, 0, "t4");
      check("t4_failed_state", state, 2'b10);
      check("t4_failed_mask", fault_mask, 3'b110);
      cycle(1, 8'h33, 8'h44, 8'h55, 1, 0, "t4n");
      check("t4_single_data", bus.out_data, 8'h33);
      check("t4_single_err", bus.out_err, 1);

      // Clear with a simultaneous accept: word keeps FAILED flags
      cycle(1, 8'h66, 8'h66, 8'h66, 1, 1, "t6c");
      check("t6_clr_word_err", bus.out_err, 1);
      check("t6_clr_mask", fault_mask, 3'b000);
      check("t6_clr_state", state, 2'b00);

      // Back-pressure with a pending word, then release
      cycle(1, 8'h10, 8'h10, 8'h10, 1, 0, "t5a");
      for (int i = 0; i < 3; i++) begin
         cycle(1, 8'h20, 8'h20, 8'h20, 0, 0, "t5s");
         check("t5_held_data", bus.out_data, 8'h10);
         check("t5_in_ready_low", bus.in_ready, 0);
      end
      cycle(1, 8'h20, 8'h20, 8'h20, 1, 0, "t5r");
      check("t5_first_after_release", bus.out_data, 8'h20);
      cycle(1, 8'h21, 8'h21, 8'h21, 1, 0, "t5r");
      cycle(1, 8'h22, 8'h22, 8'h22, 1, 0, "t5r");
      check("t5_third_after_release", bus.out_data, 8'h22);
      cycle(0, 8'h00, 8'h00, 8'h00, 1, 0, "t5d");

      // Random traffic; C is the flakiest channel so the modes get exercised
      for (int n = 0; n < 2000; n++) begin
         base = 8'($urandom_range(0, 255));
         va = ($urandom_range(0, 9) == 0)  ? 8'($urandom_range(0, 255)) : base;
         vb = ($urandom_range(0, 4) == 0)  ? 8'($urandom_range(0, 255)) : base;
         vc = ($urandom_range(0, 9) < 6)   ? 8'($urandom_range(0, 255)) : base;
         cycle(1'($urandom_range(0, 3) != 0), va, vb, vc,
               1'($urandom_range(0, 9) < 7), 1'($urandom_range(0, 149) == 0), "rnd");
      end

      // Async reset mid-burst drops the pending word immediately
      cycle(1, 8'h77, 8'h77, 8'h77, 0, 0, "t6b");
      cycle(1, 8'h78, 8'h78, 8'h78, 0, 0, "t6b");
      #2 rst_n = 1'b0;
      #1;
      model_reset();
      check("t6_async_valid", bus.out_valid, 0);
      check("t6_async_state", state, 2'b00);
      @(negedge clk) rst_n = 1'b1;
      cycle(0, 0, 0, 0, 1, 0, "post_rst");

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
